ttt_move_ctrl: RTL and testbench
================================

Name: ttt_move_ctrl

Overview:
Upstream of the winner checker in the tic-tac-toe datapath. Owns the 3x3 board register and validates and places player moves. Alternates turns and auto-plays on turn timeout. After each placement it pulses en_check to the winner checker, then samples the checker's winner one cycle later to end the game or pass the turn.

Parameters:
TIMEOUT_CYCLES, 750000000, clk cycles allowed per turn before auto-placement (15 s at 50 MHz); must be >= 2.
TW, $clog2(TIMEOUT_CYCLES), turn timer width.

Ports:
clk  in  1  system clock; all flops rise-edge.
rst_n  in  1  asynchronous active-low reset.
new_game  in  1  synchronous pulse; restart game.
move_valid  in  1  move request strobe, one cycle.
move_row  in  2  target row, legal 1..3.
move_col  in  2  target column, legal 1..3.
winner  in  2  from checker: 0 none, 1 X, 2 O, 3 draw; valid the cycle after en_check.
board  out  2x[3:1][3:1]  cell codes: 0 empty, 1 X, 2 O.
en_check  out  1  one-cycle request to the checker.
cur_player  out  2  player to move, 1 or 2.
move_accept  out  1  one-cycle pulse: a move was placed (user or auto).
move_reject  out  1  one-cycle pulse: request refused.
auto_move  out  1  one-cycle pulse coincident with move_accept when the timeout placed the move.
game_over  out  1  level; high in state DONE.
result  out  2  latched final winner code; 0 while the game runs.

Behaviour:
- Reset (rst_n=0, async): board all 0, cur_player=1, state=WAIT, timer=0, all pulses 0, game_over=0, result=0.
- All outputs are registered; pulses last exactly one cycle.
- States: WAIT, CHECK, EVAL, DONE.
- WAIT:
  - timer increments each cycle.
  - move_valid with row/col in 1..3 and target cell == 0: write cur_player to the cell, pulse move_accept, clear timer, go to CHECK.
  - move_valid with row or col == 0, or occupied target: pulse move_reject; board, timer and state unchanged.
  - Timer reaching TIMEOUT_CYCLES-1 with no accepted move that cycle: place cur_player in the first empty cell in row-major scan (1,1),(1,2)...(3,3). Pulse move_accept and auto_move, clear timer, go to CHECK.
  - Valid move and timeout in the same cycle: the user move wins; no auto_move.
  - No empty cell found at timeout (unreachable in legal play): result=3, go to DONE.
- CHECK: en_check=1 for exactly this cycle; move_valid is ignored (no accept or reject pulse).
- EVAL: sample winner.
  - Nonzero: latch result=winner, go to DONE.
  - 0: toggle cur_player (1<->2), go to WAIT with timer=0.
  - move_valid ignored.
- DONE: game_over=1; board frozen; move_valid ignored; timer held at 0.
- new_game pulse, in any state, overrides all other inputs that cycle:
  - next cycle: board cleared, cur_player=1, result=0, game_over=0, timer=0, state=WAIT.
  - Any en_check or move pulse that would have been produced is suppressed.
  - new_game during CHECK/EVAL discards the pending winner.
- Latency: move_valid in cycle N -> board and move_accept visible N+1 (CHECK, en_check=1) -> N+2 EVAL -> N+3 WAIT with cur_player toggled, or DONE.
- Turn rate: at most one accepted move per 3 cycles.
- Out-of-range row/col values are treated as illegal, never truncated or wrapped.

Test Plan:
- Reset, then X (1,1), O (2,1), X (1,2), O (2,2), X (1,3), with the checker model returning 1 after the last move -> board row 1 = 1,1,1; result=1; game_over=1; a later move_valid is ignored (no pulses).
- X at (2,2), then O requests (2,2) -> move_reject pulse, cell stays 1, cur_player stays 2, timer not cleared. Then O requests row=0,col=1 -> move_reject.
- TIMEOUT_CYCLES=10, cells (1,1),(1,2) occupied, no input for 9 cycles -> (1,3)=cur_player with move_accept and auto_move pulses, en_check the next cycle.
- Nine alternating legal moves with checker returning 0 then 3 -> result=3, game_over=1, cur_player unchanged after the final EVAL.
- new_game asserted in the CHECK cycle -> next cycle board all 0, cur_player=1, state WAIT, no EVAL-driven toggle; winner=1 on the following cycle is ignored.
- rst_n dropped mid-game in WAIT with timer at 5 -> all outputs at reset values immediately (async), timer=0 after release.

Source files
------------

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller: owns the board, validates and places
// moves, handles turn timeout and hands each placement to the checker.
module ttt_move_ctrl #(
   parameter int TIMEOUT_CYCLES = 750000000,
   parameter int TW = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  new_game,
   input  logic                  move_valid,
   input  logic [1:0]            move_row,
   input  logic [1:0]            move_col,
   input  logic [1:0]            winner,
   output logic [3:1][3:1][1:0]  board,
   output logic                  en_check,
   output logic [1:0]            cur_player,
   output logic                  move_accept,
   output logic                  move_reject,
   output logic                  auto_move,
   output logic                  game_over,
   output logic [1:0]            result
);

   typedef enum logic [1:0] {
      WAIT,
      CHECK,
      EVAL,
      DONE
   } state_t;

   state_t               state;
   state_t               state_n;
   logic [TW-1:0]        timer;
   logic [TW-1:0]        timer_n;
   logic [3:1][3:1][1:0] board_n;
   logic [1:0]           player_n;
   logic [1:0]           result_n;
   logic                 accept_n;
   logic                 reject_n;
   logic                 auto_n;
   logic                 check_n;
   logic                 over_n;
   logic                 occupied;
   logic                 legal;
   logic                 timeout;
   logic                 found;
   logic [1:0]           auto_r;
   logic [1:0]           auto_c;

   // Target-cell legality and turn timeout for the current request
   always_comb begin
      occupied = 1'b0;
      if (move_row != 2'd0 && move_col != 2'd0)
         occupied = (board[move_row][move_col] != 2'd0);
      legal   = move_valid && (move_row != 2'd0) && (move_col != 2'd0)
                && !occupied;
      timeout = (timer == TW'(TIMEOUT_CYCLES - 1));
   end

   // First empty cell in row-major order; scanning backwards leaves the
   // earliest hit as the final assignment
   always_comb begin
      found  = 1'b0;
      auto_r = 2'd0;
      auto_c = 2'd0;
      for (int r = 3; r >= 1; r--) begin
         for (int c = 3; c >= 1; c--) begin
            if (board[r][c] == 2'd0) begin
               found  = 1'b1;
               auto_r = 2'(r);
               auto_c = 2'(c);
            end
         end
      end
   end

   // Next-state, board update and next values of all registered outputs
   always_comb begin
      state_n  = state;
      timer_n  = timer;
      board_n  = board;
      player_n = cur_player;
      result_n = result;
      accept_n = 1'b0;
      reject_n = 1'b0;
      auto_n   = 1'b0;
      case (state)
         WAIT: begin
            timer_n = timer + TW'(1);
            if (legal) begin
               board_n[move_row][move_col] = cur_player;
               accept_n = 1'b1;
               timer_n  = '0;
               state_n  = CHECK;
            end else begin
               reject_n = move_valid;
               if (timeout) begin
                  timer_n = '0;
                  if (found) begin
                     board_n[auto_r][auto_c] = cur_player;
                     accept_n = 1'b1;
                     auto_n   = 1'b1;
                     state_n  = CHECK;
                  end else begin
                     result_n = 2'd3;
                     state_n  = DONE;
                  end
               end
            end
         end
         CHECK: begin
            state_n = EVAL;
         end
         EVAL: begin
            if (winner != 2'd0) begin
               result_n = winner;
               state_n  = DONE;
            end else begin
               player_n = (cur_player == 2'd1) ? 2'd2 : 2'd1;
               timer_n  = '0;
               state_n  = WAIT;
            end
         end
         DONE: begin
            timer_n = '0;
         end
         default: begin
            state_n = WAIT;
            timer_n = '0;
         end
      endcase
      if (new_game) begin
         state_n  = WAIT;
         timer_n  = '0;
         board_n  = '0;
         player_n = 2'd1;
         result_n = 2'd0;
         accept_n = 1'b0;
         reject_n = 1'b0;
         auto_n   = 1'b0;
      end
      check_n = (state_n == CHECK);
      over_n  = (state_n == DONE);
   end

   // State, board and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= WAIT;
         timer       <= '0;
         board       <= '0;
         cur_player  <= 2'd1;
         result      <= 2'd0;
         move_accept <= 1'b0;
         move_reject <= 1'b0;
         auto_move   <= 1'b0;
         en_check    <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         state       <= state_n;
         timer       <= timer_n;
         board       <= board_n;
         cur_player  <= player_n;
         result      <= result_n;
         move_accept <= accept_n;
         move_reject <= reject_n;
         auto_move   <= auto_n;
         en_check    <= check_n;
         game_over   <= over_n;
      end
   end

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Directed bench for ttt_move_ctrl with a scoreboard queue of expected
// per-cycle outputs and a small winner-checker stand-in.
module tb_ttt_move_ctrl;

   localparam int TO = 10;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 new_game = 1'b0;
   logic                 move_valid = 1'b0;
   logic [1:0]           move_row = 2'd0;
   logic [1:0]           move_col = 2'd0;
   logic [1:0]           winner;
   logic [3:1][3:1][1:0] board;
   logic                 en_check;
   logic [1:0]           cur_player;
   logic                 move_accept;
   logic                 move_reject;
   logic                 auto_move;
   logic                 game_over;
   logic [1:0]           result;
   logic [1:0]           model_win = 2'd0;

   int   checks = 0;
   int   failures = 0;
   logic [8:0] sb[$];
   string      tags[$];

   always #5 clk = ~clk;

   ttt_move_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .new_game(new_game),
      .move_valid(move_valid),
      .move_row(move_row),
      .move_col(move_col),
      .winner(winner),
      .board(board),
      .en_check(en_check),
      .cur_player(cur_player),
      .move_accept(move_accept),
      .move_reject(move_reject),
      .auto_move(auto_move),
      .game_over(game_over),
      .result(result)
   );

   // Checker stand-in: answers model_win the cycle after en_check
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) winner <= 2'd0;
      else        winner <= en_check ? model_win : 2'd0;
   end

   function automatic logic [8:0] ex(input logic acc, input logic rej,
                                     input logic aut, input logic enc,
                                     input logic [1:0] cp, input logic go,
                                     input logic [1:0] res);
      return {acc, rej, aut, enc, cp, go, res};
   endfunction

   task automatic compare();
      logic [8:0] e;
      logic [8:0] o;
      string      t;
      e = sb.pop_front();
      t = tags.pop_front();
      o = {move_accept, move_reject, auto_move, en_check,
           cur_player, game_over, result};
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s got=%b expected=%b (acc rej aut enc cp go res)",
                t, o, e);
      end
   endtask

   task automatic step(input string t, input logic mv,
                       input logic [1:0] r, input logic [1:0] c,
                       input logic ng, input logic [8:0] e);
      move_valid = mv;
      move_row   = r;
      move_col   = c;
      new_game   = ng;
      sb.push_back(e);
      tags.push_back(t);
      @(posedge clk);
      #1;
      move_valid = 1'b0;
      new_game   = 1'b0;
      move_row   = 2'd0;
      move_col   = 2'd0;
      compare();
   endtask

   task automatic chk_cell(input string t, input int r, input int c,
                           input logic [1:0] v);
      checks++;
      assert (board[r][c] === v) else begin
         failures++;
         $error("FAIL %s cell(%0d,%0d) got=%0d expected=%0d",
                t, r, c, board[r][c], v);
      end
   endtask

   task automatic idle(input string t, input int n, input logic [1:0] cp);
      for (int i = 0; i < n; i++)
         step(t, 1'b0, 2'd0, 2'd0, 1'b0, ex(0, 0, 0, 0, cp, 0, 2'd0));
   endtask

   task automatic play(input logic [1:0] r, input logic [1:0] c,
                       input logic [1:0] p, input logic [1:0] w);
      model_win = w;
      step("move", 1'b1, r, c, 1'b0, ex(1, 0, 0, 1, p, 0, 2'd0));
      step("check", 1'b0, 2'd0, 2'd0, 1'b0, ex(0, 0, 0, 0, p, 0, 2'd0));
      if (w == 2'd0)
         step("eval", 1'b0, 2'd0, 2'd0, 1'b0,
              ex(0, 0, 0, 0, 2'd3 - p, 0, 2'd0));
      else
         step("eval_end", 1'b0, 2'd0, 2'd0, 1'b0,
              ex(0, 0, 0, 0, p, 1, w));
      chk_cell("placed", int'(r), int'(c), p);
   endtask

   initial begin
      // reset state
      #12;
      sb.push_back(ex(0, 0, 0, 0, 2'd1, 0, 2'd0));
      tags.push_back("reset");
      compare();
      checks++;
      assert (board === '0) else begin
         failures++;
         $error("FAIL reset_board got=%h expected=0", board);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // X wins on row 1
      play(2'd1, 2'd1, 2'd1, 2'd0);
      play(2'd2, 2'd1, 2'd2, 2'd0);
      play(2'd1, 2'd2, 2'd1, 2'd0);
      play(2'd2, 2'd2, 2'd2, 2'd0);
      play(2'd1, 2'd3, 2'd1, 2'd1);
      chk_cell("row1", 1, 1, 2'd1);
      chk_cell("row1", 1, 2, 2'd1);
      chk_cell("row1", 1, 3, 2'd1);
      step("done_ignore", 1'b1, 2'd3, 2'd3, 1'b0,
           ex(0, 0, 0, 0, 2'd1, 1, 2'd1));
      chk_cell("done_frozen", 3, 3, 2'd0);

      // rejects keep the timer running; timeout fills first empty cell
      step("newgame", 1'b0, 2'd0, 2'd0, 1'b1, ex(0, 0, 0, 0, 2'd1, 0, 2'd0));
      chk_cell("cleared", 1, 1, 2'd0);
      play(2'd2, 2'd2, 2'd1, 2'd0);
      step("rej_occ", 1'b1, 2'd2, 2'd2, 1'b0, ex(0, 1, 0, 0, 2'd2, 0, 2'd0));
      chk_cell("rej_keep", 2, 2, 2'd1);
      step("rej_row0", 1'b1, 2'd0, 2'd1, 1'b0, ex(0, 1, 0, 0, 2'd2, 0, 2'd0));
      idle("wait_o", TO - 3, 2'd2);
      step("auto_o", 1'b0, 2'd0, 2'd0, 1'b0, ex(1, 0, 1, 1, 2'd2, 0, 2'd0));
      chk_cell("auto_o_cell", 1, 1, 2'd2);
      step("auto_chk", 1'b0, 2'd0, 2'd0, 1'b0, ex(0, 0, 0, 0, 2'd2, 0, 2'd0));
      step("auto_eval", 1'b0, 2'd0, 2'd0, 1'b0, ex(0, 0, 0, 0, 2'd1, 0, 2'd0));

      // timeout skips occupied (1,1),(1,2)
      step("newgame2", 1'b0, 2'd0, 2'd0, 1'b1, ex(0, 0, 0, 0, 2'd1, 0, 2'd0));
      play(2'd1, 2'd1, 2'd1, 2'd0);
      play(2'd1, 2'd2, 2'd2, 2'd0);
      idle("wait_x", TO - 1, 2'd1);
      step("auto_x", 1'b0, 2'd0, 2'd0, 1'b0, ex(1, 0, 1, 1, 2'd1, 0, 2'd0));
      chk_cell("auto_x_cell", 1, 3, 2'd1);
      step("auto_x_chk", 1'b0, 2'd0, 2'd0, 1'b0,
           ex(0, 0, 0, 0, 2'd1, 0, 2'd0));
      step("auto_x_eval", 1'b0, 2'd0, 2'd0, 1'b0,
           ex(0, 0, 0, 0, 2'd2, 0, 2'd0));

      // full board, draw
      step("newgame3", 1'b0, 2'd0, 2'd0, 1'b1, ex(0, 0, 0, 0, 2'd1, 0, 2'd0));
      play(2'd1, 2'd1, 2'd1, 2'd0);
      play(2'd1, 2'd2, 2'd2, 2'd0);
      play(2'd1, 2'd3, 2'd1, 2'd0);
      play(2'd2, 2'd1, 2'd2, 2'd0);
      play(2'd2, 2'd2, 2'd1, 2'd0);
      play(2'd2, 2'd3, 2'd2, 2'd0);
      play(2'd3, 2'd1, 2'd1, 2'd0);
      play(2'd3, 2'd2, 2'd2, 2'd0);
      play(2'd3, 2'd3, 2'd1, 2'd3);
      idle("draw_hold", 0, 2'd1);
      step("draw_idle", 1'b0, 2'd0, 2'd0, 1'b0, ex(0, 0, 0, 0, 2'd1, 1, 2'd3));

      // new_game during CHECK discards the pending winner
      step("newgame4", 1'b0, 2'd0, 2'd0, 1'b1, ex(0, 0, 0, 0, 2'd1, 0, 2'd0));
      model_win = 2'd1;
      step("ng_move", 1'b1, 2'd1, 2'd1, 1'b0, ex(1, 0, 0, 1, 2'd1, 0, 2'd0));
      step("ng_check", 1'b0, 2'd0, 2'd0, 1'b1, ex(0, 0, 0, 0, 2'd1, 0, 2'd0));
      checks++;
      assert (board === '0) else begin
         failures++;
         $error("FAIL ng_board got=%h expected=0", board);
      end
      step("ng_win_ign", 1'b0, 2'd0, 2'd0, 1'b0, ex(0, 0, 0, 0, 2'd1, 0, 2'd0));
      model_win = 2'd0;
      step("ng_wait", 1'b1, 2'd2, 2'd2, 1'b0, ex(1, 0, 0, 1, 2'd1, 0, 2'd0));
      step("chk_ignore", 1'b1, 2'd3, 2'd3, 1'b0, ex(0, 0, 0, 0, 2'd1, 0, 2'd0));
      step("eval_ignore", 1'b1, 2'd3, 2'd3, 1'b0,
           ex(0, 0, 0, 0, 2'd2, 0, 2'd0));
      chk_cell("ignored_cell", 3, 3, 2'd0);

      // async reset mid-turn, timer restarts from 0
      idle("pre_rst", 5, 2'd2);
      rst_n = 1'b0;
      #1;
      sb.push_back(ex(0, 0, 0, 0, 2'd1, 0, 2'd0));
      tags.push_back("async_rst");
      compare();
      chk_cell("rst_cell", 2, 2, 2'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle("post_rst", TO - 1, 2'd1);
      step("rst_auto", 1'b0, 2'd0, 2'd0, 1'b0, ex(1, 0, 1, 1, 2'd1, 0, 2'd0));
      chk_cell("rst_auto_cell", 1, 1, 2'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
